fetch_queue: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter and upstream of the IF/ID boundary. It owns the fetch address, issues one-outstanding-request reads to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small prefetch FIFO. Decode drains the FIFO with a valid/ready handshake. The block handles branch redirects (flush plus re-steer) and stops fetching after a HALT opcode.

---
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory req/ack port and IF/ID valid/ready port.
// Optional FETCH_STALL_CNT_EN adds the stall_cnt debug output.
interface fetch_queue_if;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        id_ready;
  logic        halted;
  logic [15:0] fetch_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  // The fetch unit masters both the memory request and the decode-facing queue head.
  modport master (
    input  redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc, halted, fetch_pc
`ifdef FETCH_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, halted, fetch_pc
`ifdef FETCH_STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: one-outstanding imem reads into a DEPTH-entry prefetch FIFO with redirect and HALT.
// Optional macro FETCH_STALL_CNT_EN adds a saturating stall-cycle counter (stall_cnt).
module fetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_DRAIN,
    ST_HALT
  } state_t;

  state_t        state;
  logic          imem_req;
  logic [15:0]   imem_addr;
  logic [15:0]   fetch_pc;
  logic          halted;

  logic [15:0]   fifo_instr [DEPTH];
  logic [15:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          ack;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic          is_halt;
  logic          has_space;
  logic [CW-1:0] count_next;

  // Redirect outranks push and pop: a flushing cycle neither stores nor consumes an entry.
  assign ack        = imem_req & bus.imem_ack;
  assign head_valid = (count != '0);
  assign push       = (state == ST_WAIT) & ack & ~bus.redirect_valid;
  assign pop        = head_valid & bus.id_ready & ~bus.redirect_valid;
  assign count_next = count + CW'(push) - CW'(pop);
  assign has_space  = (count_next < CW'(DEPTH));
  assign is_halt    = (bus.imem_rdata[15:12] == HALT_OPCODE);

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = imem_addr;
  assign bus.fetch_pc  = fetch_pc;
  assign bus.halted    = halted;
  assign bus.id_valid  = head_valid;
  assign bus.id_instr  = head_valid ? fifo_instr[rd_ptr] : '0;
  assign bus.id_pc     = head_valid ? fifo_pc[rd_ptr]    : '0;

  // NOTE: all state here is updated with <= so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
      halted    <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (bus.redirect_valid) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= bus.redirect_pc;
      halted   <= 1'b0;
      unique case (state)
        ST_WAIT, ST_DRAIN: begin
          // An outstanding read must still complete on the bus; its data is dropped.
          if (ack) begin
            imem_req <= 1'b0;
            state    <= ST_RUN;
          end else begin
            state    <= ST_DRAIN;
          end
        end
        ST_RUN, ST_HALT: state <= ST_RUN;
      endcase
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;

      unique case (state)
        ST_RUN: begin
          if (has_space) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ack) begin
            fetch_pc <= imem_addr + 16'd1;
            if (is_halt) begin
              imem_req <= 1'b0;
              halted   <= 1'b1;
              state    <= ST_HALT;
            end else if (has_space) begin
              imem_addr <= imem_addr + 16'd1;
            end else begin
              imem_req <= 1'b0;
              state    <= ST_RUN;
            end
          end
        end
        ST_DRAIN: begin
          if (ack) begin
            imem_req <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_HALT: begin
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; contents are only visible while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]    <= imem_addr;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (bus.redirect_valid) begin
      stall_cnt <= '0;
    end else if (imem_req && !bus.imem_ack && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared every cycle plus directed literals.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          halt_en  = 1'b0;
  logic [15:0] halt_addr = 16'h0;
  bit          ack_en   = 1'b1;
  int          ack_delay = 0;
  int          wait_n   = 0;
  int          hs_cnt   = 0;
  logic [15:0] pops[$];
  logic [15:0] last_pop = 16'h0;

  // Instruction memory contents: never a HALT opcode except at the armed halt address.
  function automatic logic [15:0] mem_word(logic [15:0] a, bit hen, logic [15:0] haddr);
    if (hen && a == haddr) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr, halt_en, halt_addr);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack after ack_delay waiting cycles per request.
  initial begin
    bus.imem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst || !ack_en || !bus.imem_req) begin
        bus.imem_ack = 1'b0;
        wait_n = 0;
      end else begin
        if (bus.imem_ack) wait_n = 0;
        if (wait_n >= ack_delay) bus.imem_ack = 1'b1;
        else begin
          bus.imem_ack = 1'b0;
          wait_n++;
        end
      end
    end
  end

  // Observed handshakes and decode pops.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        if (bus.imem_req && bus.imem_ack) hs_cnt++;
        if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
          pops.push_back(bus.id_pc);
          last_pop = bus.id_pc;
        end
      end
    end
  end

  // Reference model: a queue of {pc,instr}, one outstanding-read flag and a discard flag.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        q[$];
  bit          m_out  = 1'b0;
  bit          m_disc = 1'b0;
  bit          m_halt = 1'b0;
  logic [15:0] m_addr = RESET_PC;
  logic [15:0] m_fpc  = RESET_PC;
  logic [15:0] m_stall = 16'h0;
  bit          m_hs;
  logic [15:0] m_word;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_out = 1'b0; m_disc = 1'b0; m_halt = 1'b0;
        m_addr = RESET_PC; m_fpc = RESET_PC; m_stall = 16'h0;
      end else begin
        m_hs = m_out && bus.imem_ack;
        if (bus.redirect_valid) m_stall = 16'h0;
        else if (m_out && !bus.imem_ack && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;

        if (bus.redirect_valid) begin
          q.delete();
          m_fpc  = bus.redirect_pc;
          m_halt = 1'b0;
          if (m_out && !m_hs) m_disc = 1'b1;
          else begin
            m_out  = 1'b0;
            m_disc = 1'b0;
          end
        end else begin
          if (q.size() > 0 && bus.id_ready) void'(q.pop_front());
          if (m_hs) begin
            if (m_disc) begin
              m_out  = 1'b0;
              m_disc = 1'b0;
            end else begin
              m_word = mem_word(m_addr, halt_en, halt_addr);
              q.push_back('{pc: m_addr, instr: m_word});
              m_fpc = m_addr + 16'd1;
              if (m_word[15:12] == 4'hF) begin
                m_out  = 1'b0;
                m_halt = 1'b1;
              end else if (q.size() < DEPTH) m_addr = m_addr + 16'd1;
              else m_out = 1'b0;
            end
          end else if (!m_out && !m_halt && q.size() < DEPTH) begin
            m_out  = 1'b1;
            m_addr = m_fpc;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("imem_req", bus.imem_req, m_out);
      if (m_out) check("imem_addr", bus.imem_addr, m_addr);
      check("id_valid", bus.id_valid, q.size() > 0);
      check("id_pc", bus.id_pc, (q.size() > 0) ? q[0].pc : 16'h0);
      check("id_instr", bus.id_instr, (q.size() > 0) ? q[0].instr : 16'h0);
      check("halted", bus.halted, m_halt);
      check("fetch_pc", bus.fetch_pc, m_fpc);
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt", bus.stall_cnt, m_stall);
`endif
    end
  end

  task automatic redirect_to(input logic [15:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_hs(input int max, output bit ok);
    int h;
    h  = hs_cnt;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (hs_cnt != h) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int          h0;
    int          n5;
    bit          ok;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] s0;
`endif
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0;
    bus.id_ready       = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 16'h0000);
    check("rst_fetch_pc", bus.fetch_pc, 16'h0000);
    check("rst_id_valid", bus.id_valid, 1'b0);
    check("rst_halted", bus.halted, 1'b0);
    rst = 1'b1;

    // Streaming with ack and ready held high
    @(negedge clk);
    check("first_req", bus.imem_req, 1'b1);
    check("first_addr", bus.imem_addr, 16'h0000);
    @(negedge clk);
    check("stream_addr1", bus.imem_addr, 16'h0001);
    check("stream_pc0", bus.id_pc, 16'h0000);
    @(negedge clk);
    check("stream_addr2", bus.imem_addr, 16'h0002);
    check("stream_pc1", bus.id_pc, 16'h0001);
    check("stream_instr1", bus.id_instr, 16'h1001);
    repeat (5) @(negedge clk);

    // Back-pressure: one entry already buffered, so DEPTH-1 more fill the FIFO
    h0 = hs_cnt;
    bus.id_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("fill_hs", hs_cnt - h0, DEPTH - 1);
    check("fill_req_low", bus.imem_req, 1'b0);
    check("fill_id_valid", bus.id_valid, 1'b1);
    h0 = hs_cnt;
    bus.id_ready = 1'b1;
    @(negedge clk);
    bus.id_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("one_slot_hs", hs_cnt - h0, 1);
    check("one_slot_req_low", bus.imem_req, 1'b0);

    // HALT at address 0003
    halt_addr = 16'h0003;
    halt_en   = 1'b1;
    bus.id_ready = 1'b1;
    redirect_to(16'h0000);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.halted) begin
        ok = 1'b1;
        break;
      end
    end
    check("halt_seen", ok, 1'b1);
    h0 = hs_cnt;
    repeat (6) @(negedge clk);
    check("halt_req_low", bus.imem_req, 1'b0);
    check("halt_still", bus.halted, 1'b1);
    check("halt_drained", bus.id_valid, 1'b0);
    check("halt_last_pc", last_pop, 16'h0003);
    check("halt_no_hs", hs_cnt - h0, 0);
    halt_en = 1'b0;
    redirect_to(16'h0040);
    check("resume_halted", bus.halted, 1'b0);
    @(negedge clk);
    check("resume_req", bus.imem_req, 1'b1);
    check("resume_addr", bus.imem_addr, 16'h0040);

    // Redirect while waiting on a slow read: the read completes and is discarded
    ack_delay = 3;
    redirect_to(16'h0005);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.imem_req && bus.imem_addr == 16'h0005) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait5_seen", ok, 1'b1);
    pops.delete();
    redirect_to(16'h0100);
    check("drain_addr_a", bus.imem_addr, 16'h0005);
    @(negedge clk);
    check("drain_addr_b", bus.imem_addr, 16'h0005);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == 16'h0100) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_next_req", ok, 1'b1);
    ack_delay = 0;
    repeat (8) @(negedge clk);
    n5 = 0;
    foreach (pops[i]) if (pops[i] == 16'h0005) n5++;
    check("drain_discard", n5, 0);
    check("drain_first_pop", pops[0], 16'h0100);

    // Full FIFO across the FFFF->0000 wrap, then redirect plus pop in one cycle
    bus.id_ready = 1'b0;
    redirect_to(16'hFFFD);
    repeat (10) @(negedge clk);
    check("wrap_full_req", bus.imem_req, 1'b0);
    check("wrap_head", bus.id_pc, 16'hFFFD);
    pops.delete();
    bus.id_ready = 1'b1;
    redirect_to(16'hFFFE);
    check("flush_empty", bus.id_valid, 1'b0);
    repeat (8) @(negedge clk);
    check("flush_pop0", pops[0], 16'hFFFE);
    check("wrap_pop1", pops[1], 16'hFFFF);
    check("wrap_pop2", pops[2], 16'h0000);

`ifdef FETCH_STALL_CNT_EN
    // Stall counter: five wait cycles per instruction, cleared on redirect
    ack_delay = 5;
    wait_hs(30, ok);
    check("stall_hs_a", ok, 1'b1);
    s0 = bus.stall_cnt;
    wait_hs(30, ok);
    check("stall_hs_b", ok, 1'b1);
    check("stall_step", bus.stall_cnt - s0, 16'd5);
    redirect_to(16'h0200);
    check("stall_clear", bus.stall_cnt, 16'h0000);
    ack_delay = 0;
    repeat (4) @(negedge clk);
`endif

    // Asynchronous reset in the middle of a request
    ack_en = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_req", bus.imem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_req", bus.imem_req, 1'b0);
    check("async_addr", bus.imem_addr, RESET_PC);
    check("async_id_valid", bus.id_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    ack_en = 1'b1;
    wait_hs(10, ok);
    check("post_reset_hs", ok, 1'b1);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
